// File: rtl/gpio_seq_monitor.sv
// Receive-side checker for the one-hot GPIO walking sequence.
// Verifies one-hot encoding, ascending order with wrap, and per-step dwell.
module gpio_seq_monitor #(
    parameter int NUM_PINS       = 34,
    parameter int TICKS_PER_UNIT = 10000,
    parameter int TOL            = 1,
    parameter int CNT_W          = 28
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                enable,
    input  logic [13:0]         prescaler,
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic [5:0]          step_idx,
    output logic                sweep_done,
    output logic [15:0]         sweep_count,
    output logic                locked,
    output logic                error,
    output logic [2:0]          err_code
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_TRACK,
        S_ERR
    } state_t;

    localparam logic [NUM_PINS-1:0] PIN0    = NUM_PINS'(1);
    localparam logic [NUM_PINS-1:0] PIN_TOP = PIN0 << (NUM_PINS - 1);
    localparam logic [CNT_W:0]      TOL_W   = (CNT_W + 1)'(TOL);

    state_t              state_q;
    logic [5:0]          step_q;
    logic                done_q;
    logic [15:0]         count_q;
    logic                locked_q;
    logic                error_q;
    logic [2:0]          code_q;
    logic [CNT_W-1:0]    dwell_q;
    logic [NUM_PINS-1:0] prev_q;
    logic                first_q;

    logic [CNT_W:0]      exp_w;
    logic [CNT_W:0]      hi_w;
    logic [CNT_W:0]      lo_w;
    logic [CNT_W:0]      dwell_inc;
    logic [CNT_W-1:0]    dwell_d;
    logic                one_hot;
    logic                is_next;
    logic                is_wrap;
    logic                chk;
    logic                too_short;
    logic                too_long;

    // Bounds are one bit wider so exp+TOL cannot overflow the compare.
    always_comb begin
        exp_w     = {1'b0, CNT_W'(prescaler) * CNT_W'(TICKS_PER_UNIT)};
        hi_w      = exp_w + TOL_W;
        lo_w      = (exp_w > TOL_W) ? exp_w - TOL_W : '0;
        dwell_inc = {1'b0, dwell_q} + (CNT_W + 1)'(1);
        dwell_d   = (&dwell_q) ? dwell_q : dwell_q + CNT_W'(1);
        one_hot   = (gpio_in != '0) &&
                    ((gpio_in & (gpio_in - PIN0)) == '0);
        is_next   = gpio_in == (prev_q << 1);
        is_wrap   = (prev_q == PIN_TOP) && (gpio_in == PIN0);
        chk       = (prescaler != '0) && !first_q;
        too_short = chk && ({1'b0, dwell_q} < lo_w);
        too_long  = chk && (dwell_inc > hi_w);
    end

    always_ff @(posedge clk) begin
        if (!nrst || !enable) begin
            state_q  <= S_IDLE;
            step_q   <= '0;
            done_q   <= 1'b0;
            count_q  <= '0;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
            code_q   <= '0;
            dwell_q  <= '0;
            prev_q   <= '0;
            first_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: state_q <= S_WAIT;
                S_WAIT: begin
                    if (gpio_in == PIN0) begin
                        state_q <= S_TRACK;
                        step_q  <= '0;
                        dwell_q <= CNT_W'(1);
                        prev_q  <= gpio_in;
                        first_q <= 1'b1;
                    end else if (gpio_in != '0) begin
                        state_q <= S_ERR;
                        error_q <= 1'b1;
                        code_q  <= one_hot ? 3'd2 : 3'd1;
                    end
                end
                S_TRACK: begin
                    if (gpio_in == prev_q) begin
                        dwell_q <= dwell_d;
                        if (too_long) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                            code_q  <= 3'd4;
                        end
                    end else if (gpio_in == '0) begin
                        state_q  <= S_WAIT;
                        step_q   <= '0;
                        locked_q <= 1'b0;
                        dwell_q  <= '0;
                        prev_q   <= '0;
                        first_q  <= 1'b1;
                    end else if (!one_hot) begin
                        state_q <= S_ERR;
                        error_q <= 1'b1;
                        code_q  <= 3'd1;
                    end else if (!is_next && !is_wrap) begin
                        state_q <= S_ERR;
                        error_q <= 1'b1;
                        code_q  <= 3'd2;
                    end else if (too_short) begin
                        state_q <= S_ERR;
                        error_q <= 1'b1;
                        code_q  <= 3'd3;
                    end else begin
                        step_q  <= is_wrap ? '0 : step_q + 6'd1;
                        dwell_q <= CNT_W'(1);
                        prev_q  <= gpio_in;
                        first_q <= 1'b0;
                        if (chk) locked_q <= 1'b1;
                        if (is_wrap) begin
                            done_q  <= 1'b1;
                            count_q <= count_q + 16'd1;
                        end
                    end
                end
                S_ERR: state_q <= S_ERR;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign step_idx    = step_q;
    assign sweep_done  = done_q;
    assign sweep_count = count_q;
    assign locked      = locked_q;
    assign error       = error_q;
    assign err_code    = code_q;

endmodule

// File: tb/tb_gpio_seq_monitor.sv
// Directed bench for gpio_seq_monitor with a queue-based scoreboard.
// Uses a short TICKS_PER_UNIT so full sweeps stay within a small run.
module tb_gpio_seq_monitor;

    localparam int NP  = 34;
    localparam int TPU = 10;

    typedef struct {
        string       tag;
        logic [27:0] val;
        logic [27:0] mask;
    } exp_t;

    logic          clk = 1'b0;
    logic          nrst;
    logic          enable;
    logic [13:0]   prescaler;
    logic [NP-1:0] gpio_in;
    logic [5:0]    step_idx;
    logic          sweep_done;
    logic [15:0]   sweep_count;
    logic          locked;
    logic          error;
    logic [2:0]    err_code;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   pulses = 0;
    int   p0;

    gpio_seq_monitor #(
        .NUM_PINS(NP),
        .TICKS_PER_UNIT(TPU),
        .TOL(1),
        .CNT_W(28)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .enable(enable),
        .prescaler(prescaler),
        .gpio_in(gpio_in),
        .step_idx(step_idx),
        .sweep_done(sweep_done),
        .sweep_count(sweep_count),
        .locked(locked),
        .error(error),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (sweep_done) pulses <= pulses + 1;

    function automatic logic [NP-1:0] pin(input int p);
        logic [NP-1:0] r;
        r = NP'(1);
        return r << p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string t, input logic [5:0] st,
                        input logic d, input logic [15:0] c,
                        input logic l, input logic e,
                        input logic [2:0] k,
                        input logic [27:0] m = '1);
        exp_t x;
        x.tag  = t;
        x.val  = {st, d, c, l, e, k};
        x.mask = m;
        q.push_back(x);
    endtask

    task automatic tick_chk();
        exp_t        x;
        logic [27:0] obs;
        tick();
        tests++;
        if (q.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty: got none want entry");
        end else begin
            x   = q.pop_front();
            obs = {step_idx, sweep_done, sweep_count,
                   locked, error, err_code};
            assert ((obs & x.mask) === (x.val & x.mask)) else begin
                fails++;
                $error("FAIL %s: got %h want %h", x.tag,
                       obs & x.mask, x.val & x.mask);
            end
        end
    endtask

    task automatic hold(input logic [NP-1:0] v, input int n);
        gpio_in = v;
        repeat (n) tick();
    endtask

    task automatic restart();
        gpio_in = '0;
        enable  = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        nrst      = 1'b0;
        enable    = 1'b0;
        prescaler = '0;
        gpio_in   = '0;
        tick();
        push("reset", 0, 0, 0, 0, 0, 0);
        tick_chk();
        nrst = 1'b1;
        tick();
        tick();
        push("idle", 0, 0, 0, 0, 0, 0);
        tick_chk();
        prescaler = 14'd1;
        enable    = 1'b1;
        tick();
        push("wait", 0, 0, 0, 0, 0, 0);
        tick_chk();

        // two clean sweeps
        p0 = pulses;
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < NP; p++) begin
                gpio_in = pin(p);
                push("clean", 6'(p), (s == 1 && p == 0), 16'(s),
                     (s == 1 || p >= 2), 0, 0);
                tick_chk();
                push("clean_hold", 6'(p), 0, 16'(s),
                     (s == 1 || p >= 2), 0, 0);
                tick_chk();
                repeat (TPU - 2) tick();
            end
        end
        gpio_in = pin(0);
        push("clean_end", 0, 1, 2, 1, 0, 0);
        tick_chk();
        push("clean_end_hold", 0, 0, 2, 1, 0, 0);
        tick_chk();
        tests++;
        assert ((pulses - p0) === 2) else begin
            fails++;
            $error("FAIL pulse_count: got %0d want 2", pulses - p0);
        end
        gpio_in = '0;
        push("clean_stop", 0, 0, 2, 0, 0, 0, 28'h03F_FFFF);
        tick_chk();

        // order fault
        for (int p = 0; p < 4; p++) hold(pin(p), TPU);
        gpio_in = pin(5);
        push("order", 3, 0, 2, 1, 1, 2);
        tick_chk();
        gpio_in = pin(6);
        push("order_frozen", 3, 0, 2, 1, 1, 2);
        tick_chk();
        gpio_in = '0;
        push("order_frozen0", 3, 0, 2, 1, 1, 2);
        tick_chk();
        enable = 1'b0;
        push("order_clear", 0, 0, 0, 0, 0, 0);
        tick_chk();

        // one-hot fault
        restart();
        for (int p = 0; p < 5; p++) hold(pin(p), TPU);
        gpio_in = pin(4) | pin(5);
        push("onehot", 4, 0, 0, 1, 1, 1);
        tick_chk();
        gpio_in = pin(6);
        push("onehot_h1", 4, 0, 0, 1, 1, 1);
        tick_chk();
        gpio_in = pin(7);
        push("onehot_h2", 4, 0, 0, 1, 1, 1);
        tick_chk();
        gpio_in = pin(0);
        push("onehot_h3", 4, 0, 0, 1, 1, 1);
        tick_chk();

        // short dwell: 9 clocks is the lower bound, 8 fails
        restart();
        hold(pin(0), TPU);
        hold(pin(1), TPU);
        hold(pin(2), TPU - 1);
        gpio_in = pin(3);
        push("short_ok9", 3, 0, 0, 1, 0, 0);
        tick_chk();
        repeat (TPU - 3) tick();
        gpio_in = pin(4);
        push("short", 3, 0, 0, 1, 1, 3);
        tick_chk();

        // long dwell: 11 clocks tolerated, error at the 12th edge
        restart();
        hold(pin(0), TPU);
        hold(pin(1), TPU + 1);
        gpio_in = pin(2);
        push("long_ok11", 2, 0, 0, 1, 0, 0);
        tick_chk();
        repeat (TPU - 1) tick();
        push("long_edge11", 2, 0, 0, 1, 0, 0);
        tick_chk();
        push("long", 2, 0, 0, 1, 1, 4);
        tick_chk();

        // stop mid-sweep and restart with a one-clock first step
        restart();
        for (int p = 0; p < NP; p++) hold(pin(p), TPU);
        for (int p = 0; p < 13; p++) hold(pin(p), TPU);
        gpio_in = '0;
        push("stop", 0, 0, 1, 0, 0, 0, 28'h03F_FFFF);
        tick_chk();
        tick();
        gpio_in = pin(0);
        push("restart", 0, 0, 1, 0, 0, 0);
        tick_chk();
        gpio_in = pin(1);
        push("restart_p1", 1, 0, 1, 0, 0, 0);
        tick_chk();
        repeat (TPU - 1) tick();
        gpio_in = pin(2);
        push("restart_p2", 2, 0, 1, 1, 0, 0);
        tick_chk();

        // prescaler=0 disables dwell checks
        prescaler = '0;
        repeat (3 * TPU) tick();
        gpio_in = pin(3);
        push("ps0", 3, 0, 1, 1, 0, 0);
        tick_chk();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gpio_seq_monitor.md
Name: gpio_seq_monitor

Overview:
- Receive-side checker for the one-hot GPIO walking sequence driven by the team's sample project sequencer.
- Samples a NUM_PINS-wide GPIO bus and verifies three properties: one-hot encoding, strict ascending step order with wrap from the top pin to pin 0, and per-step dwell time equal to prescaler × TICKS_PER_UNIT clocks.
- Reports sweep completions, current step and a sticky error code. Intended for in-design self-test and for loopback checks on the GPIO pads.

Parameters:
- NUM_PINS, 34, width of the monitored GPIO bus.
- TICKS_PER_UNIT, 10000, clocks per prescaler unit (1 ms at 10 MHz).
- TOL, 1, allowed ± clock deviation of a step's dwell from its expected value.
- CNT_W, 28, dwell counter width. Must hold 14-bit prescaler × TICKS_PER_UNIT + TOL.

Ports:
- clk  input  1  system clock
- nrst  input  1  reset, synchronous, active-low
- enable  input  1  monitor enable; low forces IDLE and clears all outputs
- prescaler  input  14  expected dwell in TICKS_PER_UNIT units; 0 disables dwell checks
- gpio_in  input  NUM_PINS  observed GPIO bus, same clock domain, no synchroniser
- step_idx  output  6  index of the currently high pin while tracking
- sweep_done  output  1  one-cycle pulse per completed sweep (wrap from top pin to pin 0)
- sweep_count  output  16  completed sweeps since tracking started, wraps at 2^16
- locked  output  1  high once at least one dwell check has passed
- error  output  1  sticky error flag
- err_code  output  3  first error seen: 0 none, 1 not one-hot, 2 order, 3 dwell short, 4 dwell long

Behaviour:
- Single clock domain. One clock; reset is synchronous and active-low (clk, nrst).
- Reset and enable=0 have the same effect:
  - state=IDLE.
  - step_idx=0, sweep_done=0, sweep_count=0, locked=0, error=0, err_code=0.
  - Dwell counter=0, prev register=0, first-step flag=1.
- All outputs are registered. Every decision is made at the clock edge that first samples a new gpio_in value, comparing gpio_in against prev; outputs reflect that decision from that edge onward.
- Expected dwell: exp = prescaler × TICKS_PER_UNIT, computed as an unsigned CNT_W-bit product.
- States:
  - IDLE: if enable=1, go to WAIT_START.
  - WAIT_START: gpio_in must be all-zero or exactly pin 0 high.
    - gpio_in == 1: go to TRACK, step_idx=0, dwell=1, prev=gpio_in, first-step flag=1.
    - Any other non-zero value: go to ERROR with err_code=1 if not one-hot, else err_code=2.
  - TRACK, gpio_in == prev:
    - dwell increments, saturating at all-ones.
    - If prescaler≠0 and dwell+1 > exp+TOL and first-step flag=0: go to ERROR with err_code=4 at that edge.
  - TRACK, gpio_in != prev (checks in priority order):
    - gpio_in == 0: legal stop. Go to WAIT_START, no error, sweep_count holds, locked cleared.
    - Not one-hot: err_code=1.
    - Not equal to prev<<1 and not the wrap case (prev=pin NUM_PINS-1, gpio_in=pin 0): err_code=2.
    - prescaler≠0, first-step flag=0, and dwell < exp−TOL: err_code=3.
    - Otherwise legal:
      - step_idx advances, or becomes 0 on wrap.
      - dwell=1, prev=gpio_in, first-step flag=0.
      - locked=1 if a dwell check was performed.
      - On wrap: sweep_done=1 for this cycle only, sweep_count increments.
  - ERROR: all outputs frozen, error=1, err_code holds the first error. Exit only via enable=0 or reset.
- First-step exemption: the step entered from WAIT_START is never dwell-checked, because its start alignment is unknown (the sequencer's first step may be one clock long).
- prescaler change while tracking takes effect at the next comparison. No retroactive checks.
- sweep_done is never asserted in WAIT_START or ERROR.

Test Plan:
- Power-on: nrst=0 for 2 clocks, enable=0 → all outputs 0. Release nrst, gpio_in=0 → outputs stay 0.
- Clean run: prescaler=1, enable=1, drive pin0..pin33 for 10000 clocks each for two sweeps, then pin 0 → sweep_done pulses exactly twice (1 cycle each), sweep_count=2, locked=1, error=0, step_idx=0.
- Order fault: pin3 followed by pin5 → error=1 and err_code=2 at the edge sampling pin5; outputs frozen until enable=0, which clears everything.
- One-hot fault: pins 4 and 5 high together → err_code=1. Hold the bus for 3 more transitions → err_code remains 1.
- Dwell faults, prescaler=1, TOL=1:
  - A non-first step held 9998 clocks → err_code=3.
  - A non-first step held 10001 clocks → no error.
  - A step still high at clock 10002 → err_code=4 at that edge, without waiting for a transition.
- Stop/restart: gpio_in to 0 mid-sweep at pin 12 → WAIT_START, error=0, locked=0, sweep_count holds. Restart at pin 0 → tracking resumes with the first step exempt from dwell checks.
